// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter: round-robin write-back scheduler for the register file
// write port, with post-reset zeroing of x1..x(2^AW-1).   Revision: 1.0
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NREQ           = 3,
    parameter int AW             = 5,
    parameter int DW             = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 we_o,
    output logic [AW-1:0]        waddr_o,
    output logic [DW-1:0]        wdata_o,
    output logic                 busy_o,
    output logic [2:0]           grant_id_o,
    output logic [15:0]          drop_cnt_o
);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam state_t INIT_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    state_t         state;
    state_t         state_next;
    logic [AW-1:0]  clr_cnt;
    logic [2:0]     rr_ptr;

    logic           xfer;
    logic [2:0]     sel_idx;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_data;
    logic [4:0]     sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= INIT_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_cnt == '1) begin
            state_next = RUN;
        end
    end

    // Scan pointer+1 .. pointer+NREQ (mod NREQ); first valid requester wins.
    always_comb begin
        req_ready = '0;
        xfer      = 1'b0;
        sel_idx   = '0;
        sel_addr  = '0;
        sel_data  = '0;
        sum       = '0;
        if (state == RUN) begin
            for (int k = 1; k <= NREQ; k++) begin
                sum = 5'(rr_ptr) + 5'(k);
                if (sum >= 5'(NREQ)) begin
                    sum = sum - 5'(NREQ);
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (!xfer && sum == 5'(i) && req_valid[i]) begin
                        xfer         = 1'b1;
                        req_ready[i] = 1'b1;
                        sel_idx      = 3'(i);
                        sel_addr     = req_addr[i*AW +: AW];
                        sel_data     = req_data[i*DW +: DW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_cnt    <= AW'(1);
            rr_ptr     <= 3'(NREQ - 1);
            we_o       <= 1'b0;
            waddr_o    <= '0;
            wdata_o    <= '0;
            grant_id_o <= '0;
            drop_cnt_o <= '0;
        end else if (state == CLEAR) begin
            we_o    <= 1'b1;
            waddr_o <= clr_cnt;
            wdata_o <= '0;
            clr_cnt <= clr_cnt + AW'(1);
        end else if (xfer) begin
            rr_ptr     <= sel_idx;
            grant_id_o <= sel_idx;
            waddr_o    <= sel_addr;
            wdata_o    <= sel_data;
            we_o       <= (sel_addr != '0);
            if (sel_addr == '0 && drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end else begin
            we_o <= 1'b0;
        end
    end

    assign busy_o = (state == CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_arbiter: directed bench for regfile_wb_arbiter (NREQ=3).
// Revision: 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        busy_o;
    logic [2:0]  grant_id_o;
    logic [15:0] drop_cnt_o;

    int asserts = 0;
    int fails   = 0;

    logic [31:0] rf [0:31];
    logic [31:0] rr_data [0:2];

    regfile_wb_arbiter #(
        .NREQ(3), .AW(5), .DW(32), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .we_o(we_o), .waddr_o(waddr_o),
        .wdata_o(wdata_o), .busy_o(busy_o), .grant_id_o(grant_id_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    // Behavioural register file fed by the arbiter's write port.
    always @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < 32; r++) rf[r] <= 32'hFFFF_FFFF;
        end else if (we_o && waddr_o != 5'd0) begin
            rf[waddr_o] <= wdata_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int nz;
        rr_data[0] = 32'h0000_0011;
        rr_data[1] = 32'h0000_0022;
        rr_data[2] = 32'h0000_0033;
        rst       = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        repeat (3) step();

        // Reset values
        check("rst_we",    {31'd0, we_o},        32'd0);
        check("rst_waddr", {27'd0, waddr_o},     32'd0);
        check("rst_wdata", wdata_o,              32'd0);
        check("rst_gid",   {29'd0, grant_id_o},  32'd0);
        check("rst_drop",  {16'd0, drop_cnt_o},  32'd0);
        check("rst_busy",  {31'd0, busy_o},      32'd1);

        // Release reset (cycle 0) with requester 2 pending through the clear.
        rst       = 1'b1;
        req_valid = 3'b100;
        req_addr  = {5'd6, 5'd0, 5'd0};
        req_data  = {32'd4, 32'd0, 32'd0};
        #1;
        check("c0_busy",  {31'd0, busy_o},    32'd1);
        check("c0_we",    {31'd0, we_o},      32'd0);
        check("c0_ready", {29'd0, req_ready}, 32'd0);

        for (int c = 1; c <= 31; c++) begin
            step();
            check($sformatf("clr%0d_we", c),    {31'd0, we_o},     32'd1);
            check($sformatf("clr%0d_waddr", c), {27'd0, waddr_o},  32'(c));
            check($sformatf("clr%0d_wdata", c), wdata_o,           32'd0);
            check($sformatf("clr%0d_busy", c),  {31'd0, busy_o},   (c <= 30) ? 32'd1 : 32'd0);
            check($sformatf("clr%0d_ready", c), {29'd0, req_ready}, (c == 31) ? 32'd4 : 32'd0);
        end

        // Cycle 32: pending request 2 written; clear fully committed.
        step();
        check("c32_we",    {31'd0, we_o},       32'd1);
        check("c32_waddr", {27'd0, waddr_o},    32'd6);
        check("c32_wdata", wdata_o,             32'd4);
        check("c32_gid",   {29'd0, grant_id_o}, 32'd2);
        nz = 0;
        for (int r = 1; r < 32; r++) if (rf[r] !== 32'd0) nz++;
        check("clear_nonzero_regs", 32'(nz), 32'd0);

        // Round-robin: all three valid continuously, pointer sits at 2.
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {rr_data[2], rr_data[1], rr_data[0]};
        #1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr%0d_ready", k), {29'd0, req_ready}, 32'd1 << (k % 3));
            step();
            check($sformatf("rr%0d_we", k),    {31'd0, we_o},       32'd1);
            check($sformatf("rr%0d_gid", k),   {29'd0, grant_id_o}, 32'(k % 3));
            check($sformatf("rr%0d_waddr", k), {27'd0, waddr_o},    32'((k % 3) + 1));
            check($sformatf("rr%0d_wdata", k), wdata_o,             rr_data[k % 3]);
        end
        req_valid = '0;
        check("rf6_committed", rf[6], 32'd4);

        // Single grant from requester 0 (pointer at 2).
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd5};
        req_data  = {32'd0, 32'd0, 32'd5};
        #1;
        check("sg_ready", {29'd0, req_ready}, 32'd1);
        step();
        check("sg_we",    {31'd0, we_o},       32'd1);
        check("sg_waddr", {27'd0, waddr_o},    32'd5);
        check("sg_wdata", wdata_o,             32'd5);
        check("sg_gid",   {29'd0, grant_id_o}, 32'd0);
        req_valid = '0;
        #1;
        check("idle_ready", {29'd0, req_ready}, 32'd0);
        step();
        check("idle_we",    {31'd0, we_o},    32'd0);
        check("idle_waddr", {27'd0, waddr_o}, 32'd5);
        check("idle_wdata", wdata_o,          32'd5);
        check("rf5",        rf[5],            32'd5);

        // x0 drop from requester 1.
        req_valid = 3'b010;
        req_addr  = {5'd0, 5'd0, 5'd0};
        req_data  = {32'd0, 32'hDEAD_BEEF, 32'd0};
        #1;
        check("x0_ready", {29'd0, req_ready}, 32'd2);
        step();
        check("x0_we",    {31'd0, we_o},       32'd0);
        check("x0_drop",  {16'd0, drop_cnt_o}, 32'd1);
        check("x0_gid",   {29'd0, grant_id_o}, 32'd1);
        check("x0_wdata", wdata_o,             32'hDEAD_BEEF);
        req_valid = '0;

        // Mid-clear reset.
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int c = 1; c <= 10; c++) step();
        check("mc_waddr10", {27'd0, waddr_o}, 32'd10);
        rst = 1'b0;
        step();
        check("mc_rst_we",   {31'd0, we_o},       32'd0);
        check("mc_rst_drop", {16'd0, drop_cnt_o}, 32'd0);
        check("mc_rst_gid",  {29'd0, grant_id_o}, 32'd0);
        rst = 1'b1;
        step();
        check("mc_restart_we",    {31'd0, we_o},    32'd1);
        check("mc_restart_waddr", {27'd0, waddr_o}, 32'd1);
        check("mc_restart_busy",  {31'd0, busy_o},  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port scheduler for the 32x32 register file. Shares the file's single write port (write enable, 5-bit address, 32-bit data) between NREQ write-back requesters (e.g. ALU, load unit, CSR) using round-robin arbitration with a valid/ready handshake. After reset it runs a clear sequence that zeroes registers 1..31 through the same port. It drops writes to x0 and sits directly in front of the register file's write inputs.

## Interface
- NREQ, 3: number of requesters, 2..8.
- AW, 5: register address width.
- DW, 32: data width.
- CLEAR_ON_RESET, 1: 1 runs the zeroing sequence after reset; 0 enters RUN immediately.

- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- req_valid  input  NREQ  bit i = requester i holds a write.
- req_addr  input  NREQ*AW  requester i address in bits [i*AW +: AW].
- req_data  input  NREQ*DW  requester i data in bits [i*DW +: DW].
- req_ready  output  NREQ  one-hot grant, combinational.
- we_o  output  1  register-file write enable, registered.
- waddr_o  output  AW  register-file write address, registered.
- wdata_o  output  DW  register-file write data, registered.
- busy_o  output  1  high while state is CLEAR.
- grant_id_o  output  3  index of last accepted requester, registered.
- drop_cnt_o  output  16  count of accepted writes to x0, registered, saturating.

## Operation
**States**
- CLEAR: a counter walks addresses 1..2^AW-1. Each cycle writes 0 to the current address. req_ready is all 0.
- RUN: normal arbitration.

**Reset**
- When rst=0 at a rising edge:
  - state <= CLEAR if CLEAR_ON_RESET=1, else RUN.
  - Clear counter <= 1.
  - RR pointer <= NREQ-1, so requester 0 has top priority on the first grant.
  - we_o, waddr_o, wdata_o, grant_id_o, drop_cnt_o <= 0.
- A reset during CLEAR or RUN aborts all activity and restarts the sequence from address 1. A write already on we_o in that cycle completes, because the register file samples it on the same edge.

**Arbitration (RUN)**
- Search order is pointer+1, pointer+2, … modulo NREQ. The first requester with req_valid set gets req_ready.
- At most one ready bit is high. A transfer happens when req_valid[i] & req_ready[i].
- On a transfer:
  - RR pointer <= i.
  - grant_id_o <= i.
  - waddr_o <= req_addr[i], wdata_o <= req_data[i].
  - we_o <= (req_addr[i] != 0).
- A transfer to address 0 is accepted (ready high) but produces we_o=0 next cycle. drop_cnt_o increments and saturates at 0xFFFF.
- With no transfer, we_o <= 0. waddr_o and wdata_o hold.
- Requester rules: once req_valid is high, it stays high with addr and data stable until accepted. A deasserting requester is a protocol violation; the arbiter does not check for it.
- A requester may issue back-to-back requests. Under contention each requester waits at most NREQ-1 cycles between grants.

**CLEAR**
- Each cycle: waddr_o <= counter, wdata_o <= 0, we_o <= 1.
- counter increments each cycle.
- After loading address 2^AW-1, state <= RUN.
- The clear sequence ignores req_valid; requests stay pending.

## Timing
- Write latency: a grant in cycle T puts we_o/waddr_o/wdata_o in cycle T+1. The register file commits at the end of T+1.
- req_ready depends combinationally on req_valid and registered state only. There is no path from outputs back to ready.
- Clear sequence (AW=5), with cycle 0 = first cycle with rst=1:
  - busy_o=1 in cycles 0..30.
  - we_o=1 with waddr_o = 1..31 in cycles 1..31.
  - Earliest req_ready is cycle 31. Earliest request write on we_o is cycle 32.
- CLEAR_ON_RESET=0: req_ready is possible in cycle 0, and busy_o stays 0.
- Throughput: one write per cycle in RUN.

## Test plan
- **Clear:** release rst, no requests → we_o=1 for exactly 31 cycles, waddr_o 1..31, wdata_o 0, busy_o falls after cycle 30. A following register-file readback returns 0 for every register.
- **Single grant:** after clear, req0 valid with addr 5, data 0x00000005 → req_ready=3'b001 the same cycle; next cycle we_o=1, waddr_o=5, wdata_o=5, grant_id_o=0.
- **Round-robin:** all three requesters valid continuously with distinct addrs 1/2/3 → grant order 0,1,2,0,1,2. Each requester is granted exactly once every 3 cycles.
- **x0 drop:** req1 writes addr 0, data 0xDEADBEEF → req_ready[1]=1, we_o=0 next cycle, drop_cnt_o increments 0→1. Register 0 reads 0.
- **Request during clear:** req2 valid (addr 6, data 4) from cycle 0 → no ready before cycle 31; accepted in cycle 31; we_o with addr 6, data 4 in cycle 32.
- **Mid-clear reset:** assert rst=0 at cycle 10 of clear → the next release restarts at waddr_o=1, and drop_cnt_o and grant_id_o read 0.
